// File: rtl/logiana_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logiana_pkg
// Description : Shared widths, readout FSM states and byte-select helper.
// Revision    : 1.0 - initial release
// ============================================================================
package logiana_pkg;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FILL   = 3'd3,
        ST_STREAM = 3'd4
    } state_t;

    // Byte idx of a sample word, byte 0 being the least significant.
    function automatic logic [7:0] byte_sel(input logic [DATA_W-1:0] word,
                                            input logic [1:0]        idx);
        byte_sel = word[8*idx +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/logiana_strobe_sync.sv
`default_nettype none
// ============================================================================
// Module      : logiana_strobe_sync
// Description : Synchroniser and rising-edge detector for an active-low host strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module logiana_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_strobe_n,
    output logic o_level_n,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Idle level of the strobe is high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_strobe_n};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level_n = r_sync[SYNC_STAGES-1];
    assign o_rise    = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/logiana_readout.sv
`default_nettype none
// ============================================================================
// Module      : logiana_readout
// Description : Streams captured 32-bit samples from sync SRAM to the 8-bit host bus.
// Revision    : 1.0 - initial release
// ============================================================================
module logiana_readout #(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 32,
    parameter int RAM_LAT     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK24,
    input  logic              RST,
    input  logic              START,
    input  logic [ADDR_W-1:0] START_ADDR,
    input  logic              ENABLE,
    input  logic              H_nRD,
    output logic [7:0]        H_DOUT,
    output logic              H_DOE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_nADSC,
    output logic              RAM_nOE,
    input  logic [DATA_W-1:0] RAM_DQ_IN,
    output logic              BUSY,
    output logic              UNDERRUN,
    output logic [ADDR_W-1:0] WORD_CNT
);

    import logiana_pkg::*;

    localparam int c_WAIT_W = $clog2(RAM_LAT + 1);

    logic w_nrd_level;
    logic w_nrd_rise;
    logic w_consume;
    logic w_fill_sel;
    logic [1:0] w_valid_nxt;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_fetch_addr;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [ADDR_W-1:0]   r_word_cnt;
    logic                r_nadsc;
    logic                r_noe;
    logic                r_doe;
    logic                r_underrun;
    logic [7:0]          r_dout;
    logic [DATA_W-1:0]   r_buf [2];
    logic [1:0]          r_valid;
    logic                r_cur;
    logic [1:0]          r_byte_idx;
    logic [c_WAIT_W-1:0] r_wait_cnt;

    logiana_strobe_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rd_sync (
        .clk        (CLK24),
        .rst        (RST),
        .i_strobe_n (H_nRD),
        .o_level_n  (w_nrd_level),
        .o_rise     (w_nrd_rise)
    );

    // A read ending outside readout mode or before any START is not a consume.
    assign w_consume  = w_nrd_rise & ENABLE & (r_state != ST_IDLE);
    assign w_fill_sel = r_valid[r_cur] ? ~r_cur : r_cur;

    always_comb begin
        w_valid_nxt = r_valid;
        if (r_state == ST_FILL) begin
            w_valid_nxt[w_fill_sel] = 1'b1;
        end
        if (w_consume && r_valid[r_cur] && (r_byte_idx == 2'd3)) begin
            w_valid_nxt[r_cur] = 1'b0;
        end
    end

    always_ff @(posedge CLK24 or posedge RST) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_fetch_addr <= '0;
            r_ram_addr   <= '0;
            r_word_cnt   <= '0;
            r_nadsc      <= 1'b1;
            r_noe        <= 1'b1;
            r_doe        <= 1'b0;
            r_underrun   <= 1'b0;
            r_dout       <= 8'h00;
            r_buf[0]     <= '0;
            r_buf[1]     <= '0;
            r_valid      <= 2'b00;
            r_cur        <= 1'b0;
            r_byte_idx   <= 2'd0;
            r_wait_cnt   <= '0;
        end else begin
            r_dout <= byte_sel(r_buf[r_cur], r_byte_idx);
            r_doe  <= ENABLE & ~w_nrd_level;

            if (START) begin
                // Restart from scratch; any read still in the SRAM pipe is never captured.
                r_state      <= ST_FETCH;
                r_fetch_addr <= START_ADDR;
                r_ram_addr   <= START_ADDR;
                r_nadsc      <= 1'b0;
                r_noe        <= 1'b0;
                r_valid      <= 2'b00;
                r_cur        <= 1'b0;
                r_byte_idx   <= 2'd0;
                r_underrun   <= 1'b0;
                r_word_cnt   <= '0;
            end else begin
                r_nadsc <= 1'b1;
                r_valid <= w_valid_nxt;

                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_FETCH: begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= c_WAIT_W'(RAM_LAT - 2);
                    end
                    ST_WAIT: begin
                        if (r_wait_cnt == '0) begin
                            r_state <= ST_FILL;
                            r_noe   <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt - c_WAIT_W'(1);
                        end
                    end
                    ST_FILL: begin
                        r_buf[w_fill_sel] <= RAM_DQ_IN;
                        r_fetch_addr      <= r_fetch_addr + ADDR_W'(1);
                        r_state           <= ST_STREAM;
                    end
                    ST_STREAM: begin
                        if (r_valid != 2'b11) begin
                            r_state    <= ST_FETCH;
                            r_ram_addr <= r_fetch_addr;
                            r_nadsc    <= 1'b0;
                            r_noe      <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase

                if (w_consume) begin
                    if (!r_valid[r_cur]) begin
                        r_underrun <= 1'b1;
                    end else begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_cur      <= ~r_cur;
                            r_word_cnt <= r_word_cnt + ADDR_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign H_DOUT    = r_dout;
    assign H_DOE     = r_doe;
    assign RAM_ADDR  = r_ram_addr;
    assign RAM_nADSC = r_nadsc;
    assign RAM_nOE   = r_noe;
    assign BUSY      = (r_state != ST_IDLE);
    assign UNDERRUN  = r_underrun;
    assign WORD_CNT  = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_logiana_readout.sv
`default_nettype none
// ============================================================================
// Module      : tb_logiana_readout
// Description : Randomised scoreboard bench for logiana_readout with SRAM and host models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logiana_readout;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          enable = 1'b1;
    logic          nrd = 1'b1;
    logic [7:0]    h_dout;
    logic          h_doe;
    logic [AW-1:0] ram_addr;
    logic          ram_nadsc;
    logic          ram_noe;
    logic [31:0]   ram_dq = '0;
    logic          busy;
    logic          underrun;
    logic [AW-1:0] word_cnt;

    always #5 clk = ~clk;

    logiana_readout dut (
        .CLK24      (clk),
        .RST        (rst),
        .START      (start),
        .START_ADDR (start_addr),
        .ENABLE     (enable),
        .H_nRD      (nrd),
        .H_DOUT     (h_dout),
        .H_DOE      (h_doe),
        .RAM_ADDR   (ram_addr),
        .RAM_nADSC  (ram_nadsc),
        .RAM_nOE    (ram_noe),
        .RAM_DQ_IN  (ram_dq),
        .BUSY       (busy),
        .UNDERRUN   (underrun),
        .WORD_CNT   (word_cnt)
    );

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // k-th byte the host should see after START at base: words ascend, LSB first, wrap.
    function automatic logic [7:0] model_byte(input logic [AW-1:0] base, input int k);
        logic [31:0] w;
        w = mem_word(AW'(base + AW'(k / 4)));
        return w[8*(k % 4) +: 8];
    endfunction

    // Pipelined SRAM: address sampled with ADSC, data valid two edges later.
    logic [AW-1:0] ram_a = '0;
    always @(posedge clk) begin
        if (!ram_nadsc) ram_a <= ram_addr;
        ram_dq <= mem_word(ram_a);
    end

    int            adsc_cnt = 0;
    logic [AW-1:0] last_fetch = '0;
    always @(posedge clk) begin
        if (!ram_nadsc) begin
            adsc_cnt   <= adsc_cnt + 1;
            last_fetch <= ram_addr;
        end
    end

    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] exp_q[$];
    bit         sb_en = 1'b1;
    logic       prev_doe = 1'b0;
    logic [7:0] exp_b;

    // Monitor: each new host read cycle presents one byte to compare.
    always @(negedge clk) begin
        if (h_doe && !prev_doe && sb_en) begin
            compared = compared + 1;
            if (exp_q.size() == 0) begin
                mismatched = mismatched + 1;
                $display("FAIL sb_byte: got %02h with no expected byte queued", h_dout);
            end else begin
                exp_b = exp_q.pop_front();
                if (h_dout !== exp_b) begin
                    mismatched = mismatched + 1;
                    $display("FAIL sb_byte: got %02h expected %02h", h_dout, exp_b);
                end
            end
        end
        prev_doe <= h_doe;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        compared = compared + 1;
        if (got !== want) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic [AW-1:0] a);
        @(negedge clk);
        start      = 1'b1;
        start_addr = a;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Host reads bytes first..first+n-1 of the stream from base with the given period.
    task automatic stream(input logic [AW-1:0] base, input int first, input int n, input int period);
        int lo;
        lo = period / 2;
        for (int k = first; k < first + n; k++) begin
            exp_q.push_back(model_byte(base, k));
            nrd = 1'b0;
            cyc(lo);
            nrd = 1'b1;
            cyc(period - lo);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"},  {24'd0, h_dout}, 32'h0);
        check({tag, "_doe"},   {31'd0, h_doe}, 32'h0);
        check({tag, "_raddr"}, {15'd0, ram_addr}, 32'h0);
        check({tag, "_nadsc"}, {31'd0, ram_nadsc}, 32'h1);
        check({tag, "_noe"},   {31'd0, ram_noe}, 32'h1);
        check({tag, "_busy"},  {31'd0, busy}, 32'h0);
        check({tag, "_undr"},  {31'd0, underrun}, 32'h0);
        check({tag, "_wcnt"},  {15'd0, word_cnt}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int            a0;
        int            n;
        logic [AW-1:0] base;

        cyc(3);
        check_reset_outputs("rst0");
        rst = 1'b0;
        cyc(3);

        // Oldest sample at 0x10, with prefetch of 0x11.
        a0 = adsc_cnt;
        do_start(17'h00010);
        cyc(10);
        check("t1_fetches", adsc_cnt - a0, 2);
        check("t1_prefetch", {15'd0, last_fetch}, 32'h11);
        check("t1_busy", {31'd0, busy}, 32'h1);
        stream(17'h00010, 0, 4, 8);
        cyc(6);
        check("t1_wcnt", {15'd0, word_cnt}, 32'h1);

        // Address wrap.
        do_start(17'h1FFFF);
        cyc(8);
        stream(17'h1FFFF, 0, 8, 10);
        cyc(6);
        check("t2_wcnt", {15'd0, word_cnt}, 32'h2);

        // Reads with ENABLE low are ignored.
        do_start(17'h00123);
        cyc(8);
        stream(17'h00123, 0, 5, 8);
        cyc(10);
        enable = 1'b0;
        a0 = adsc_cnt;
        cyc(2);
        for (int i = 0; i < 3; i++) begin
            nrd = 1'b0;
            cyc(4);
            check("t3_doe", {31'd0, h_doe}, 32'h0);
            nrd = 1'b1;
            cyc(4);
        end
        cyc(4);
        check("t3_nofetch", adsc_cnt - a0, 0);
        check("t3_wcnt", {15'd0, word_cnt}, 32'h1);
        enable = 1'b1;
        cyc(2);
        stream(17'h00123, 5, 5, 8);
        cyc(6);
        check("t3_wcnt2", {15'd0, word_cnt}, 32'h2);

        // Restart mid-word.
        do_start(17'h00200);
        cyc(8);
        stream(17'h00200, 0, 2, 8);
        cyc(4);
        do_start(17'h00040);
        cyc(8);
        stream(17'h00040, 0, 6, 8);
        cyc(6);
        check("t4_wcnt", {15'd0, word_cnt}, 32'h1);

        // Reset in the WAIT state.
        do_start(17'h00055);
        cyc(1);
        check("t5_busy", {31'd0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        check_reset_outputs("t5");
        cyc(2);
        rst = 1'b0;
        a0 = adsc_cnt;
        cyc(20);
        check("t5_noadsc", adsc_cnt - a0, 0);
        check("t5_idle", {31'd0, busy}, 32'h0);

        // Randomised streams at legal host rates.
        for (int r = 0; r < 6; r++) begin
            base = (r % 2 == 0) ? AW'($urandom) : AW'(17'h1FFFF - AW'($urandom_range(0, 6)));
            n    = $urandom_range(1, 20);
            do_start(base);
            cyc(8);
            stream(base, 0, n, $urandom_range(8, 13));
            cyc(6);
            check("rnd_wcnt", {15'd0, word_cnt}, n / 4);
            check("rnd_undr", {31'd0, underrun}, 32'h0);
        end

        // Minimum strobe period over 16 words.
        base = AW'($urandom);
        do_start(base);
        cyc(8);
        stream(base, 0, 64, 8);
        cyc(6);
        check("t6_undr_min", {31'd0, underrun}, 32'h0);
        check("t6_wcnt", {15'd0, word_cnt}, 32'h10);

        // 3-clock strobes starting right at START underrun, and the flag sticks.
        sb_en = 1'b0;
        nrd = 1'b0;
        cyc(3);
        start      = 1'b1;
        start_addr = 17'h00300;
        nrd        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            nrd = 1'b0;
            cyc(2);
            nrd = 1'b1;
            cyc(1);
        end
        cyc(4);
        check("t6_undr_set", {31'd0, underrun}, 32'h1);
        cyc(20);
        check("t6_undr_sticky", {31'd0, underrun}, 32'h1);
        do_start(17'h00400);
        cyc(1);
        check("t6_undr_clr", {31'd0, underrun}, 32'h0);

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
